// File: rtl/mem_stage.sv
// Memory-access stage: word-organised data memory with LAT-cycle access and pipeline stall.
// Byte loads/stores (sb/lb) are enabled by defining MEM_BYTE_ACCESS_EN.
module mem_stage #(
  parameter int unsigned AW  = 8,
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mrmem,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic        mbyte,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        maddr_err
);

  typedef enum logic {StIdle, StWait} state_e;

  localparam logic [3:0] LastCnt = 4'(LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem [2**AW];

  logic [AW-1:0] idx;
  logic          req;
  logic          misaligned;
  logic          aligned_req;
  logic          last;
  logic          complete;
  logic [31:0]   rdata;
  logic [31:0]   load_data;

  assign req  = mrmem | mwmem;
  assign idx  = malu[AW+1:2];
  assign rdata = mem[idx];

`ifdef MEM_BYTE_ACCESS_EN
  logic [7:0] lane_byte;

  assign misaligned = ~mbyte & (|malu[1:0]);
  assign lane_byte  = rdata[{malu[1:0], 3'b000} +: 8];
  assign load_data  = mbyte ? {{24{lane_byte[7]}}, lane_byte} : rdata;

  logic unused_bits;
  assign unused_bits = ^malu[31:AW+2];
`else
  assign misaligned = |malu[1:0];
  assign load_data  = rdata;

  logic unused_bits;
  assign unused_bits = ^{mbyte, malu[31:AW+2]};
`endif

  assign aligned_req = req & ~misaligned;
  assign last        = (state_q == StIdle) ? (LAT == 1) : (cnt_q == LastCnt);

  // Outputs are gated by clrn so an asserted reset silences them at once.
  assign complete  = clrn & aligned_req & last;
  assign mstall    = clrn & aligned_req & ~last;
  assign maddr_err = clrn & req & misaligned;
  assign mmo       = (complete & mrmem) ? load_data : 32'h0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (aligned_req && (LAT > 1)) begin
            state_q <= StWait;
            cnt_q   <= 4'd1;
          end
        end
        StWait: begin
          // A dropped request is a pipeline flush: abandon the access.
          if (!aligned_req || last) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (complete && mwmem) begin
`ifdef MEM_BYTE_ACCESS_EN
      if (mbyte) begin
        mem[idx][{malu[1:0], 3'b000} +: 8] <= mb[7:0];
      end else begin
        mem[idx] <= mb;
      end
`else
      mem[idx] <= mb;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a LAT=3 instance for the main scenarios and a LAT=1 instance.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        rmem, wmem, byt;
  logic [31:0] alu, b;
  logic [31:0] mmo;
  logic        mstall, maddr_err;

  logic        rmem1, wmem1;
  logic [31:0] alu1, b1;
  logic [31:0] mmo1;
  logic        mstall1, maddr_err1;

  int checks = 0;
  int errors = 0;

  logic [31:0] model3 [256];
  logic [31:0] model1 [256];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_stage #(.AW(8), .LAT(3)) dut3 (
    .clk      (clk),
    .clrn     (clrn),
    .mrmem    (rmem),
    .mwmem    (wmem),
    .malu     (alu),
    .mb       (b),
    .mbyte    (byt),
    .mmo      (mmo),
    .mstall   (mstall),
    .maddr_err(maddr_err)
  );

  mem_stage #(.AW(8), .LAT(1)) dut1 (
    .clk      (clk),
    .clrn     (clrn),
    .mrmem    (rmem1),
    .mwmem    (wmem1),
    .malu     (alu1),
    .mb       (b1),
    .mbyte    (1'b0),
    .mmo      (mmo1),
    .mstall   (mstall1),
    .maddr_err(maddr_err1)
  );

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                             input bit by);
    logic [7:0] bv;
    bv = w[{lane, 3'b000} +: 8];
    return by ? {{24{bv[7]}}, bv} : w;
  endfunction

  task automatic idle;
    @(posedge clk); #1;
    rmem = 1'b0; wmem = 1'b0; byt = 1'b0;
    rmem1 = 1'b0; wmem1 = 1'b0;
  endtask

  // One aligned access on the LAT=3 instance; ends at the completing cycle so calls chain
  // back-to-back with no bubble.
  task automatic access3(input bit rd, input bit wr, input bit by, input logic [31:0] addr,
                         input logic [31:0] data, input string name);
    logic [7:0]  idx;
    logic [31:0] want;
    int          stalls;
    bit          done;
    idx = addr[9:2];
    exp_q.push_back(rd ? model_load(model3[idx], addr[1:0], by) : 32'h0);
    @(posedge clk); #1;
    rmem = rd; wmem = wr; byt = by; alu = addr; b = data;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mstall === 1'b1) begin
        stalls++;
        checks++;
        if (mmo !== 32'h0) begin
          errors++;
          $display("FAIL %s mmo_in_stall got %h want 00000000", name, mmo);
        end
      end else begin
        done = 1;
        want = exp_q.pop_front();
        checks++;
        if (mmo !== want) begin
          errors++;
          $display("FAIL %s mmo got %h want %h", name, mmo, want);
        end
        checks++;
        if (stalls != 2) begin
          errors++;
          $display("FAIL %s stall_cycles got %0d want 2", name, stalls);
        end
        checks++;
        if (maddr_err !== 1'b0) begin
          errors++;
          $display("FAIL %s maddr_err got %b want 0", name, maddr_err);
        end
        if (wr) begin
          if (by) model3[idx][{addr[1:0], 3'b000} +: 8] = data[7:0];
          else model3[idx] = data;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got stall_stuck want completion", name);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic access1(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input string name);
    logic [31:0] want;
    exp_q.push_back(rd ? model1[addr[9:2]] : 32'h0);
    @(posedge clk); #1;
    rmem1 = rd; wmem1 = wr; alu1 = addr; b1 = data;
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (mstall1 !== 1'b0) begin
      errors++;
      $display("FAIL %s mstall got %b want 0", name, mstall1);
    end
    checks++;
    if (mmo1 !== want) begin
      errors++;
      $display("FAIL %s mmo got %h want %h", name, mmo1, want);
    end
    if (wr) model1[addr[9:2]] = data;
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    rmem = 1'b1; wmem = 1'b0; byt = 1'b0; alu = 32'h10; b = 32'h0;
    rmem1 = 1'b0; wmem1 = 1'b0; alu1 = 32'h0; b1 = 32'h0;
    #3;
    checks++;
    if (mstall !== 1'b0) begin errors++; $display("FAIL reset mstall got %b want 0", mstall); end
    checks++;
    if (mmo !== 32'h0) begin errors++; $display("FAIL reset mmo got %h want 0", mmo); end
    checks++;
    if (maddr_err !== 1'b0) begin
      errors++; $display("FAIL reset maddr_err got %b want 0", maddr_err);
    end
    #1 rmem = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic test_word_access;
    access3(0, 1, 0, 32'h10, 32'h12, "sw10");
    access3(1, 0, 0, 32'h10, 32'h0, "lw10");
    idle;
  endtask

  task automatic test_misaligned;
    @(posedge clk); #1;
    rmem = 1'b1; wmem = 1'b0; alu = 32'h12;
    @(negedge clk);
    checks++;
    if (maddr_err !== 1'b1) begin errors++; $display("FAIL mis_lw maddr_err got %b want 1", maddr_err); end
    checks++;
    if (mstall !== 1'b0) begin errors++; $display("FAIL mis_lw mstall got %b want 0", mstall); end
    checks++;
    if (mmo !== 32'h0) begin errors++; $display("FAIL mis_lw mmo got %h want 0", mmo); end
    @(posedge clk); #1;
    rmem = 1'b0; wmem = 1'b1; alu = 32'h13; b = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (maddr_err !== 1'b1) begin errors++; $display("FAIL mis_sw maddr_err got %b want 1", maddr_err); end
    checks++;
    if (mstall !== 1'b0) begin errors++; $display("FAIL mis_sw mstall got %b want 0", mstall); end
    access3(1, 0, 0, 32'h10, 32'h0, "lw10_after_mis");
    idle;
  endtask

  task automatic test_flush;
    access3(0, 1, 0, 32'h20, 32'h0, "sw20_zero");
    idle;
    @(posedge clk); #1;
    wmem = 1'b1; alu = 32'h20; b = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (mstall !== 1'b1) begin errors++; $display("FAIL flush_start mstall got %b want 1", mstall); end
    @(posedge clk); #1;
    wmem = 1'b0;
    @(negedge clk);
    checks++;
    if (mstall !== 1'b0) begin errors++; $display("FAIL flush_drop mstall got %b want 0", mstall); end
    access3(1, 0, 0, 32'h20, 32'h0, "lw20_after_flush");
    idle;
  endtask

  task automatic test_reset_mid_access;
    access3(0, 1, 0, 32'h30, 32'h1111_1111, "sw30");
    // Load aborted by reset while still stalling.
    @(posedge clk); #1;
    rmem = 1'b1; wmem = 1'b0; alu = 32'h30;
    @(posedge clk); #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (mstall !== 1'b0) begin errors++; $display("FAIL rst_wait mstall got %b want 0", mstall); end
    @(posedge clk); #1;
    rmem = 1'b0;
    clrn = 1'b1;
    // Store aborted by reset in its completing cycle.
    @(posedge clk); #1;
    wmem = 1'b1; alu = 32'h30; b = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (mstall !== 1'b1) begin errors++; $display("FAIL rst_sw_c1 mstall got %b want 1", mstall); end
    @(negedge clk);
    checks++;
    if (mstall !== 1'b1) begin errors++; $display("FAIL rst_sw_c2 mstall got %b want 1", mstall); end
    @(posedge clk); #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (mstall !== 1'b0 || mmo !== 32'h0) begin
      errors++; $display("FAIL rst_sw_c3 mstall/mmo got %b/%h want 0/0", mstall, mmo);
    end
    @(posedge clk); #1;
    wmem = 1'b0;
    clrn = 1'b1;
    access3(1, 0, 0, 32'h30, 32'h0, "lw30_after_rst");
    idle;
  endtask

  task automatic test_back_to_back;
    access3(0, 1, 0, 32'h40, 32'hA5A5_0001, "b2b_sw40");
    access3(1, 0, 0, 32'h40, 32'h0, "b2b_lw40");
    access3(0, 1, 0, 32'h44, 32'h0BAD_F00D, "b2b_sw44");
    access3(1, 0, 0, 32'h44, 32'h0, "b2b_lw44");
    access3(1, 1, 0, 32'h40, 32'hC0DE_CAFE, "b2b_rw40");
    access3(1, 0, 0, 32'h40, 32'h0, "b2b_lw40_new");
    access3(0, 1, 0, 32'h408, 32'h7777_0008, "alias_sw408");
    access3(1, 0, 0, 32'h8, 32'h0, "alias_lw8");
    idle;
  endtask

  task automatic test_lat1;
    access1(0, 1, 32'h4, 32'h5, "lat1_sw4");
    access1(1, 0, 32'h4, 32'h0, "lat1_lw4");
    access1(0, 1, 32'h8, 32'h9, "lat1_sw8");
    access1(1, 1, 32'h8, 32'hA, "lat1_rw8");
    access1(1, 0, 32'h8, 32'h0, "lat1_lw8");
    idle;
  endtask

`ifdef MEM_BYTE_ACCESS_EN
  task automatic test_byte;
    access3(0, 1, 0, 32'h10, 32'h12, "byte_sw10");
    access3(0, 1, 1, 32'h11, 32'hAB, "sb11");
    access3(1, 0, 1, 32'h11, 32'h0, "lb11");
    access3(1, 0, 1, 32'h10, 32'h0, "lb10");
    access3(1, 0, 0, 32'h10, 32'h0, "lw10_after_sb");
    idle;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_word_access;
    test_misaligned;
    test_flush;
    test_reset_mid_access;
    test_back_to_back;
    test_lat1;
`ifdef MEM_BYTE_ACCESS_EN
    test_byte;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
